// File: rtl/gate_sweep_pkg.sv
// Shared encodings for the gate truth-table sweep controller: op codes, FSM states, widths.
package gate_sweep_pkg;

  localparam int unsigned OP_W    = 3;
  localparam int unsigned VEC_W   = 2;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned MASK_W  = 4;
  localparam int unsigned STATE_W = 2;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd5;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  function automatic logic op_valid(input logic [OP_W-1:0] op);
    return (op <= OP_XNOR);
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational expected gate output for a given op code; invalid codes give 0.
module gate_ref_model
  import gate_sweep_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic            a,
  input  logic            b,
  output logic            y_c
);

  always_comb begin
    y_c = 1'b0;
    case (op)
      OP_AND:  y_c = a & b;
      OP_OR:   y_c = a | b;
      OP_XOR:  y_c = a ^ b;
      OP_NAND: y_c = ~(a & b);
      OP_NOR:  y_c = ~(a | b);
      OP_XNOR: y_c = ~(a ^ b);
      default: y_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Drives all four {a,b} vectors into an external 2-input gate, lets each settle,
// samples the gate output and reports per-vector mismatches against the latched op.
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [OP_W-1:0]   op_sel,
  output logic              dut_a,
  output logic              dut_b,
  input  logic              dut_y,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MASK_W-1:0] fail_mask,
  output logic              err_op
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] IDX_LAST    = VEC_W'(3);

  state_e              state_q, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [VEC_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MASK_W-1:0]   fail_mask_q, fail_mask_d;
  logic                err_op_q, err_op_d;
  logic                pass_q, pass_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                dut_a_q, dut_a_d;
  logic                dut_b_q, dut_b_d;
  logic                drive_c;
  logic                exp_y_c;

  gate_ref_model u_ref (
    .op  (op_q),
    .a   (idx_q[1]),
    .b   (idx_q[0]),
    .y_c (exp_y_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = op_valid(op_sel) ? ST_SETTLE : ST_DONE;
      ST_SETTLE: if (cnt_q == SETTLE_LAST) state_d = ST_SAMPLE;
      ST_SAMPLE: state_d = (idx_q == IDX_LAST) ? ST_DONE : ST_SETTLE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values; outputs are registered off state_d
  always_comb begin
    op_d        = op_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    fail_mask_d = fail_mask_q;
    err_op_d    = err_op_q;
    pass_d      = pass_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d        = op_sel;
          idx_d       = '0;
          cnt_d       = '0;
          fail_mask_d = '0;
          pass_d      = 1'b0;
          err_op_d    = ~op_valid(op_sel);
        end
      end
      ST_SETTLE: cnt_d = cnt_q + CNT_W'(1);
      ST_SAMPLE: begin
        if (dut_y != exp_y_c) fail_mask_d[idx_q] = 1'b1;
        if (idx_q != IDX_LAST) begin
          idx_d = idx_q + VEC_W'(1);
          cnt_d = '0;
        end
      end
      default: ;
    endcase

    drive_c = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    dut_a_d = drive_c & idx_d[1];
    dut_b_d = drive_c & idx_d[0];
    if (state_d == ST_DONE) pass_d = (fail_mask_d == '0) && !err_op_d;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      fail_mask_q <= '0;
      err_op_q    <= 1'b0;
      pass_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dut_a_q     <= 1'b0;
      dut_b_q     <= 1'b0;
    end else begin
      op_q        <= op_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      fail_mask_q <= fail_mask_d;
      err_op_q    <= err_op_d;
      pass_q      <= pass_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dut_a_q     <= dut_a_d;
      dut_b_q     <= dut_b_d;
    end
  end

  assign dut_a     = dut_a_q;
  assign dut_b     = dut_b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = fail_mask_q;
  assign err_op    = err_op_q;

endmodule

// File: doc/gate_sweep_ctrl.md
GATE_SWEEP_CTRL -- requirements
Module: gate_sweep_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, cycles a vector is held before sampling; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request to begin a truth-table sweep; sampled only in IDLE.
REQ-005 op_sel  input  3  expected gate function: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR; 6-7 invalid.
REQ-006 dut_a  output  1  gate input a driven to the device under test.
REQ-007 dut_b  output  1  gate input b driven to the device under test.
REQ-008 dut_y  input  1  gate output returned from the device under test.
REQ-009 busy  output  1  high while a sweep is in progress (any state except IDLE).
REQ-010 done  output  1  one-cycle pulse at sweep completion.
REQ-011 pass  output  1  sweep result; held until next accepted start.
REQ-012 fail_mask  output  4  bit i set when vector i ({a,b}=i) mismatched; held until next accepted start.
REQ-013 err_op  output  1  set when the accepted op_sel was invalid; held until next accepted start.

Function
REQ-014 FSM states IDLE, SETTLE, SAMPLE, DONE; binary encoded.
REQ-015 IDLE: start=1 at a rising edge latches op_sel, clears pass/fail_mask/err_op, sets vector index to 0, settle counter to 0, goes to SETTLE.
REQ-016 Invalid latched op_sel: IDLE goes directly to DONE instead; err_op=1, pass=0, fail_mask=0.
REQ-017 dut_a/dut_b = vector index bits [1]/[0] in SETTLE and SAMPLE; 0 in IDLE and DONE.
REQ-018 SETTLE: counter increments each cycle; after SETTLE_CYCLES cycles in SETTLE, goes to SAMPLE.
REQ-019 SAMPLE (one cycle): compares dut_y with the expected value for latched op and current vector; mismatch sets fail_mask[index].
REQ-020 SAMPLE with index<3: index increments, counter clears, returns to SETTLE; index=3: goes to DONE.
REQ-021 DONE (one cycle): done=1, pass=1 if fail_mask==0 and err_op==0, else 0; returns to IDLE.
REQ-022 Valid-op sweep length: 4*(SETTLE_CYCLES+1) cycles in SETTLE/SAMPLE, done asserted in cycle 4*(SETTLE_CYCLES+1)+1 after the start edge.
REQ-023 start while busy is ignored; op_sel changes after acceptance have no effect.
REQ-024 start held high continuously: a new sweep is accepted on the first IDLE edge after DONE.
REQ-025 Vector index is 2 bits and never wraps during a sweep; counter is 4 bits.

Reset
REQ-026 rst_n low forces state IDLE, dut_a=0, dut_b=0, busy=0, done=0, pass=0, fail_mask=0, err_op=0, index=0, counter=0, immediately and independent of clk.
REQ-027 Reset mid-sweep aborts without a done pulse; first start after rst_n release begins a fresh sweep.

Structure
REQ-028 Package gate_sweep_pkg holds op_sel encoding constants, FSM state encoding, and vector/counter width constants.
REQ-029 One sub-module, gate_ref_model: combinational expected output from (op, a, b); invalid op yields 0.

Verification
REQ-030 op_sel=1, DUT=OR gate, SETTLE_CYCLES=2, start pulse -> vectors 00,01,10,11 each held 3 cycles; done at cycle 13; pass=1, fail_mask=4'b0000.
REQ-031 op_sel=0 (AND) against OR gate -> pass=0, fail_mask=4'b0110, err_op=0.
REQ-032 op_sel=2 (XOR) against OR gate -> pass=0, fail_mask=4'b1000.
REQ-033 op_sel=6 -> done in cycle 1 after start; err_op=1, pass=0, fail_mask=0; dut_a=dut_b=0 throughout.
REQ-034 start re-pulsed and op_sel changed mid-sweep -> no restart; result matches the original op; exactly one done pulse.
REQ-035 rst_n low during vector 2 -> all outputs 0 without waiting for clk, no done; subsequent start completes a normal sweep with pass=1.
